// File: rtl/bch_pkg.sv
// Shared constants and FSM state type for the
// parametrised systematic BCH/cyclic encoder family.
package bch_pkg;

    localparam int BCH15_5_N = 15;
    localparam int BCH15_5_K = 5;
    localparam logic [10:0] BCH15_5_G = 11'b10100110111;

    localparam int BCH15_7_N = 15;
    localparam int BCH15_7_K = 7;
    localparam logic [8:0] BCH15_7_G = 9'b111010001;

    localparam int HAM15_11_N = 15;
    localparam int HAM15_11_K = 11;
    localparam logic [4:0] HAM15_11_G = 5'b10011;

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        HOLD
    } bch_state_t;

endpackage

// File: rtl/bch_encoder_param_lfsr.sv
// One step of the division LFSR by g(x); shared with
// the future syndrome/decoder block.
module bch_lfsr_step #(
    parameter int P = 10,
    parameter logic [P:0] GEN_POLY = 11'b10100110111
) (
    input  logic [P-1:0] r,
    input  logic         m,
    output logic [P-1:0] r_next
);

    logic fb;

    assign fb     = m ^ r[P-1];
    assign r_next = (r << 1) ^ ({P{fb}} & GEN_POLY[P-1:0]);

endmodule

// File: rtl/bch_encoder_param.sv
// Serial systematic (N,K) cyclic encoder with valid/ready
// on both sides; codeword is {msg, parity}.
module bch_encoder_param
    import bch_pkg::*;
#(
    parameter int N = 15,
    parameter int K = 5,
    parameter logic [N-K:0] GEN_POLY = BCH15_5_G
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);

    localparam int P  = N - K;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    if (N <= K || GEN_POLY[P] != 1'b1 || GEN_POLY[0] != 1'b1) begin : g_bad_poly
        $error("bch_encoder_param: invalid N/K or generator polynomial");
    end

    bch_state_t    state;
    logic [K-1:0]  msg_reg;
    logic [P-1:0]  par;
    logic [P-1:0]  par_next;
    logic [CW-1:0] cnt;

    bch_lfsr_step #(
        .P        (P),
        .GEN_POLY (GEN_POLY)
    ) u_step (
        .r      (par),
        .m      (msg_reg[cnt]),
        .r_next (par_next)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            msg_reg   <= '0;
            par       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        msg_reg <= in_data;
                        par     <= '0;
                        cnt     <= CW'(K - 1);
                        state   <= ENCODE;
                    end
                end
                ENCODE: begin
                    par <= par_next;
                    // last message bit: publish codeword on the same edge
                    if (cnt == '0) begin
                        out_data  <= {msg_reg, par_next};
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_encoder_param.sv
// Directed and random checks of bch_encoder_param in the
// (15,5) and (15,7) configurations.
module tb_bch_encoder_param;
    import bch_pkg::*;

    logic clk;
    logic rst;

    logic        iv5, rdy5, ov5, or5, busy5;
    logic [4:0]  id5;
    logic [14:0] od5;

    logic        iv7, rdy7, ov7, or7, busy7;
    logic [6:0]  id7;
    logic [14:0] od7;

    int tests;
    int fails;

    bch_encoder_param #(
        .N(15), .K(5), .GEN_POLY(BCH15_5_G)
    ) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv5),
        .in_ready  (rdy5),
        .in_data   (id5),
        .out_valid (ov5),
        .out_ready (or5),
        .out_data  (od5),
        .busy      (busy5)
    );

    bch_encoder_param #(
        .N(15), .K(7), .GEN_POLY(BCH15_7_G)
    ) dut7 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv7),
        .in_ready  (rdy7),
        .in_data   (id7),
        .out_valid (ov7),
        .out_ready (or7),
        .out_data  (od7),
        .busy      (busy7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // remainder of v modulo g(x) of degree deg, by long division
    function automatic logic [63:0] poly_mod(
        input logic [63:0] v,
        input logic [63:0] g,
        input int deg
    );
        logic [63:0] x;
        x = v;
        for (int b = 63; b >= deg; b--)
            if (x[b]) x = x ^ (g << (b - deg));
        return x;
    endfunction

    function automatic logic [14:0] ref_cw(
        input logic [63:0] msg,
        input logic [63:0] g,
        input int p
    );
        logic [63:0] v;
        v = (msg << p);
        v = v | poly_mod(v, g, p);
        return v[14:0];
    endfunction

    task automatic send5(
        input  logic [4:0]  m,
        output logic [14:0] cw,
        output int          lat
    );
        int t;
        t = 0;
        @(negedge clk);
        while (!rdy5 && t < 50) begin
            @(negedge clk);
            t++;
        end
        iv5 = 1'b1;
        id5 = m;
        @(posedge clk);
        #1 iv5 = 1'b0;
        lat = 0;
        while (!ov5 && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        cw = od5;
        or5 = 1'b1;
        @(posedge clk);
        #1 or5 = 1'b0;
    endtask

    task automatic send7(
        input  logic [6:0]  m,
        output logic [14:0] cw,
        output int          lat
    );
        int t;
        t = 0;
        @(negedge clk);
        while (!rdy7 && t < 50) begin
            @(negedge clk);
            t++;
        end
        iv7 = 1'b1;
        id7 = m;
        @(posedge clk);
        #1 iv7 = 1'b0;
        lat = 0;
        while (!ov7 && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        cw = od7;
        or7 = 1'b1;
        @(posedge clk);
        #1 or7 = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if (rdy5 !== 1'b1 || ov5 !== 1'b0 || busy5 !== 1'b0) begin
            $display("FAIL reset_ctl5 got rdy=%b ov=%b busy=%b want 1 0 0",
                     rdy5, ov5, busy5);
            fails++;
        end
        tests++;
        if (od5 !== 15'h0000) begin
            $display("FAIL reset_data5 got %h want 0000", od5);
            fails++;
        end
        tests++;
        if (rdy7 !== 1'b1 || ov7 !== 1'b0 || od7 !== 15'h0000) begin
            $display("FAIL reset_dut7 got rdy=%b ov=%b od=%h want 1 0 0000",
                     rdy7, ov7, od7);
            fails++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency;
        logic [14:0] cw;
        int lat;
        send5(5'b00001, cw, lat);
        tests++;
        if (cw !== 15'h0537) begin
            $display("FAIL cw_00001 got %h want 0537", cw);
            fails++;
        end
        tests++;
        if (lat != 5) begin
            $display("FAIL latency5 got %0d want 5", lat);
            fails++;
        end
    endtask

    task automatic test_vectors;
        logic [4:0]  msgs [3];
        logic [14:0] exp  [3];
        logic [14:0] cw;
        int lat;
        msgs = '{5'b10000, 5'b11111, 5'b00000};
        exp  = '{15'h429B, 15'h7FFF, 15'h0000};
        for (int i = 0; i < 3; i++) begin
            send5(msgs[i], cw, lat);
            tests++;
            if (cw !== exp[i]) begin
                $display("FAIL vec5_%0d got %h want %h", i, cw, exp[i]);
                fails++;
            end
        end
    endtask

    task automatic test_back_pressure;
        logic [14:0] cw;
        int lat;
        int t;
        @(negedge clk);
        iv5 = 1'b1;
        id5 = 5'b00001;
        @(posedge clk);
        #1 iv5 = 1'b0;
        t = 0;
        while (!ov5 && t < 50) begin
            @(posedge clk);
            #1 t++;
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                iv5 = 1'b1;
                id5 = 5'b10000;
            end
            @(posedge clk);
            #1;
            tests++;
            if (od5 !== 15'h0537 || ov5 !== 1'b1 || rdy5 !== 1'b0) begin
                $display("FAIL hold_%0d got od=%h ov=%b rdy=%b want 0537 1 0",
                         c, od5, ov5, rdy5);
                fails++;
            end
        end
        iv5 = 1'b0;
        or5 = 1'b1;
        @(posedge clk);
        #1 or5 = 1'b0;
        tests++;
        if (ov5 !== 1'b0 || rdy5 !== 1'b1 || busy5 !== 1'b0) begin
            $display("FAIL handshake got ov=%b rdy=%b busy=%b want 0 1 0",
                     ov5, rdy5, busy5);
            fails++;
        end
        send5(5'b11111, cw, lat);
        tests++;
        if (cw !== 15'h7FFF || lat != 5) begin
            $display("FAIL after_hold got %h lat %0d want 7fff lat 5",
                     cw, lat);
            fails++;
        end
    endtask

    task automatic test_reset_mid;
        logic [14:0] cw;
        int lat;
        bit seen;
        @(negedge clk);
        iv5 = 1'b1;
        id5 = 5'b10000;
        @(posedge clk);
        #1 iv5 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if (ov5 !== 1'b0 || od5 !== 15'h0 || rdy5 !== 1'b1 || busy5 !== 1'b0) begin
            $display("FAIL mid_reset got ov=%b od=%h rdy=%b busy=%b want 0 0000 1 0",
                     ov5, od5, rdy5, busy5);
            fails++;
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 if (ov5 || busy5) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            $display("FAIL post_reset_idle got activity want none");
            fails++;
        end
        send5(5'b00001, cw, lat);
        tests++;
        if (cw !== 15'h0537) begin
            $display("FAIL post_reset_cw got %h want 0537", cw);
            fails++;
        end
    endtask

    task automatic test_k7;
        logic [14:0] cw;
        int lat;
        send7(7'b0000001, cw, lat);
        tests++;
        if (cw !== 15'h01D1) begin
            $display("FAIL cw7_0000001 got %h want 01d1", cw);
            fails++;
        end
        tests++;
        if (lat != 7) begin
            $display("FAIL latency7 got %0d want 7", lat);
            fails++;
        end
    endtask

    task automatic test_random;
        logic [14:0] cw;
        logic [14:0] exp;
        logic [63:0] rem;
        logic [4:0]  m5;
        logic [6:0]  m7;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            m5  = 5'($urandom);
            exp = ref_cw(64'(m5), 64'(BCH15_5_G), 10);
            send5(m5, cw, lat);
            rem = poly_mod(64'(cw), 64'(BCH15_5_G), 10);
            tests++;
            if (cw !== exp || rem != 0) begin
                $display("FAIL rand5 msg %b got %h want %h", m5, cw, exp);
                fails++;
            end
        end
        for (int i = 0; i < 1000; i++) begin
            m7  = 7'($urandom);
            exp = ref_cw(64'(m7), 64'(BCH15_7_G), 8);
            send7(m7, cw, lat);
            rem = poly_mod(64'(cw), 64'(BCH15_7_G), 8);
            tests++;
            if (cw !== exp || rem != 0) begin
                $display("FAIL rand7 msg %b got %h want %h", m7, cw, exp);
                fails++;
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        iv5 = 1'b0; id5 = '0; or5 = 1'b0;
        iv7 = 1'b0; id7 = '0; or7 = 1'b0;
        test_reset;
        test_latency;
        test_vectors;
        test_back_pressure;
        test_reset_mid;
        test_k7;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
